rf_sb: RTL and testbench
========================

# rf_sb

Parametrised register file with an integrated write-back scoreboard for the next core revision, where fetch/decode, execute and write-back overlap instead of running through a strict multi-cycle state sequence. It provides NRP registered read ports with same-cycle write-back bypass, selects write-back data from the ALU, load or CSR path, and tracks pending destination registers so decode can detect RAW hazards. Register 0 is hardwired to zero.

## Interface
- XLEN, 32: register width.
- NREGS, 32: number of architectural registers; power of two, at least 2.
- NRP, 2: number of read ports.
- AW, $clog2(NREGS): register address width (derived; do not override).
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rs_en  in  NRP  per-port read enable.
- rs_addr  in  NRP*AW  per-port address; port p uses bits [p*AW +: AW].
- rs_val  out  NRP*XLEN  registered read data; port p uses bits [p*XLEN +: XLEN].
- rs_busy  out  NRP  registered flag: the register read on port p had a pending write.
- iss_en  in  1  issue strobe: mark iss_rd as pending.
- iss_rd  in  AW  destination of the issuing instruction.
- wb_en  in  1  write-back strobe.
- wb_rd  in  AW  write-back destination.
- wb_sel  in  2  data source: 0 ALU, 1 load, 2 CSR, 3 reserved (treated as ALU).
- wb_alu, wb_load, wb_csr  in  XLEN each  candidate write-back data.
- flush  in  1  clears all pending flags (pipeline squash).
- busy_any  out  1  combinational OR of all pending flags.

## Operation
- Reset (async): all registers, all pending flags, rs_val and rs_busy go to 0. busy_any goes to 0.
- Write: on an edge with wb_en=1 and wb_rd!=0, registers[wb_rd] <= wb_sel-selected data. Writes to x0 are discarded.
- Read, port p: on an edge with rs_en[p]=1, rs_val[p] <= value of rs_addr[p]. If rs_en[p]=0, rs_val[p] <= 0 and rs_busy[p] <= 0.
- Read value rules:
  - If rs_addr[p]=0, the value is 0.
  - Otherwise, if the same edge writes that address, the value is the write-back data (bypass).
  - Otherwise, the value is the stored register.
- Busy flag: rs_busy[p] <= pending[rs_addr[p]] & ~(wb_en & wb_rd==rs_addr[p]). It is always 0 for address 0. Same-cycle issue does not affect it, so an instruction's own rd never flags its sources.
- Pending flags, update priority at each edge:
  - flush clears all flags.
  - Otherwise, iss_en with iss_rd!=0 sets pending[iss_rd].
  - wb_en clears pending[wb_rd], except when iss_en targets the same rd in the same cycle; then the flag stays set (newer issue wins).
- flush does not block a same-cycle write; the register data still commits.
- All NRP ports are independent and may read the same address.

## Timing
- Read latency: 1 cycle. Address at edge N gives data and busy on the outputs after edge N.
- Write-to-read:
  - A write at edge N is visible to a read sampled at edge N through the bypass.
  - A read at edge N+1 sees the stored value.
- Issue at edge N: a read at edge N+1 reports busy.
- Write-back at edge N: a read at edge N reports not busy and gets the new data.
- busy_any is combinational from the pending flags only; it changes after the edge that updates them.
- rst asserted mid-operation: state clears immediately, with no dependence on clk. The first post-reset edge behaves as from a fresh state.

## Structure
- Shared package rf_pkg holds:
  - the WB_ALU=0, WB_LOAD=1 and WB_CSR=2 encodings;
  - the default XLEN and NREGS.
- The decode and write-back stages import the same package.
- Sub-module rf_scoreboard (params NREGS, AW): pending flags, issue/write-back/flush priority, busy lookup and busy_any.
- Top rf_sb holds:
  - the register array;
  - the write-back mux;
  - the per-port bypass and output registers, built as a generate loop over NRP.

## Test plan
- Reset then read: assert rst and read x5 and x0 on both ports → rs_val=0, rs_busy=0, busy_any=0. Also assert rst between edges → outputs clear without a clock edge.
- Write and source select:
  - Write x3 with wb_sel=1, wb_load=0xDEADBEEF, wb_alu=0x1 → a next-cycle read gives 0xDEADBEEF.
  - Write x0 with 0x1234 → a read of x0 gives 0.
  - wb_sel=3 writes wb_alu.
- Bypass: in the same cycle, write x7=0xCAFEF00D and read x7 on port 0 → rs_val[0]=0xCAFEF00D, rs_busy[0]=0.
- Scoreboard:
  - Issue rd=9, then read x9 next cycle → rs_busy=1, busy_any=1.
  - Write back x9=0x55 → the same-cycle read gives 0x55, not busy, and busy_any=0.
- Collisions:
  - Issue x4 and write back x4 in the same cycle → x4 stays pending.
  - Issue x0 → never pending.
- Flush: issue x1, x2 and x3, then flush while writing x2=0x77 → all pending flags cleared, busy_any=0, and x2 reads 0x77.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register file, decode and write-back stages:
// write-back source encodings and the default datapath geometry.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_CSR  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination tracker: one flag per architectural register, set on
// issue, cleared on write-back, wiped by flush. Register 0 is never pending.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_en_i,
    input  logic [AW-1:0]    iss_rd_i,
    input  logic             wb_en_i,
    input  logic [AW-1:0]    wb_rd_i,
    input  logic             flush_i,
    output logic [NREGS-1:0] pending_o,
    output logic             busy_any_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    assign pending_d[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_flag
            logic iss_hit;
            logic wb_hit;
            assign iss_hit = iss_en_i && (iss_rd_i == AW'(gi));
            assign wb_hit  = wb_en_i && (wb_rd_i == AW'(gi));
            // A same-cycle issue to this rd outranks its write-back: the newer producer wins.
            assign pending_d[gi] = flush_i ? 1'b0 :
                                   iss_hit ? 1'b1 :
                                   wb_hit  ? 1'b0 : pending_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o  = pending_q;
    assign busy_any_o = |pending_q;

endmodule

// File: rtl/rf_sb.sv
// Register file with write-back source mux, per-port registered reads with
// same-cycle write-back bypass, and RAW-hazard busy flags from the scoreboard.
module rf_sb
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRP   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP-1:0]      rs_en,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rs_val,
    output logic [NRP-1:0]      rs_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_rd,
    input  logic [1:0]          wb_sel,
    input  logic [XLEN-1:0]     wb_alu,
    input  logic [XLEN-1:0]     wb_load,
    input  logic [XLEN-1:0]     wb_csr,
    input  logic                flush,
    output logic                busy_any
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  wb_data;
    logic             wb_commit;
    logic [NREGS-1:0] pending;

    always_comb begin
        case (wb_sel_e'(wb_sel))
            WB_LOAD: wb_data = wb_load;
            WB_CSR:  wb_data = wb_csr;
            default: wb_data = wb_alu;
        endcase
    end

    assign wb_commit = wb_en && (wb_rd != '0);

    // Entry 0 is reset and never written, so it reads as zero everywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_commit) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .iss_en_i   (iss_en),
        .iss_rd_i   (iss_rd),
        .wb_en_i    (wb_en),
        .wb_rd_i    (wb_rd),
        .flush_i    (flush),
        .pending_o  (pending),
        .busy_any_o (busy_any)
    );

    generate
        for (genvar gi = 0; gi < NRP; gi++) begin : g_port
            logic [AW-1:0]   addr;
            logic            wb_hit;
            logic [XLEN-1:0] val_d;
            logic [XLEN-1:0] val_q;
            logic            busy_d;
            logic            busy_q;

            assign addr   = rs_addr[gi*AW +: AW];
            assign wb_hit = wb_en && (wb_rd == addr);

            always_comb begin
                val_d  = '0;
                busy_d = 1'b0;
                if (rs_en[gi] && (addr != '0)) begin
                    val_d  = wb_hit ? wb_data : regs_q[addr];
                    // Same-cycle issue is ignored here so an instruction never stalls on its own rd.
                    busy_d = pending[addr] && !wb_hit;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val_q  <= '0;
                    busy_q <= 1'b0;
                end else begin
                    val_q  <= val_d;
                    busy_q <= busy_d;
                end
            end

            assign rs_val[gi*XLEN +: XLEN] = val_q;
            assign rs_busy[gi]             = busy_q;
        end
    endgenerate

endmodule

// File: tb/tb_rf_sb.sv
// Directed bench for rf_sb: expected read results are queued when a read is
// driven and popped/compared one edge later.
module tb_rf_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRP-1:0]      rs_en;
    logic [NRP*AW-1:0]   rs_addr;
    logic [NRP*XLEN-1:0] rs_val;
    logic [NRP-1:0]      rs_busy;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                wb_en;
    logic [AW-1:0]       wb_rd;
    logic [1:0]          wb_sel;
    logic [XLEN-1:0]     wb_alu;
    logic [XLEN-1:0]     wb_load;
    logic [XLEN-1:0]     wb_csr;
    logic                flush;
    logic                busy_any;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] v0;
        logic        b0;
        logic [31:0] v1;
        logic        b1;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rf_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRP   (NRP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rs_en    (rs_en),
        .rs_addr  (rs_addr),
        .rs_val   (rs_val),
        .rs_busy  (rs_busy),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_sel   (wb_sel),
        .wb_alu   (wb_alu),
        .wb_load  (wb_load),
        .wb_csr   (wb_csr),
        .flush    (flush),
        .busy_any (busy_any)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
        $display("check %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic clear_inputs();
        rs_en   = '0;
        rs_addr = '0;
        iss_en  = 1'b0;
        iss_rd  = '0;
        wb_en   = 1'b0;
        wb_rd   = '0;
        wb_sel  = 2'd0;
        wb_alu  = '0;
        wb_load = '0;
        wb_csr  = '0;
        flush   = 1'b0;
    endtask

    task automatic set_wb(input logic [AW-1:0] rd, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] csr);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_sel  = sel;
        wb_alu  = alu;
        wb_load = ld;
        wb_csr  = csr;
    endtask

    task automatic set_iss(input logic [AW-1:0] rd);
        iss_en = 1'b1;
        iss_rd = rd;
    endtask

    task automatic set_rd(input string tag, input logic [1:0] en,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [31:0] v0, input logic b0,
                          input logic [31:0] v1, input logic b1);
        exp_t e;
        rs_en   = en;
        rs_addr = {a1, a0};
        e.tag = tag; e.v0 = v0; e.b0 = b0; e.v1 = v1; e.b1 = b1;
        exp_q.push_back(e);
    endtask

    // Sample one edge, compare any queued read result.
    task automatic edge_chk();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".val0"},  rs_val[31:0],       e.v0);
            chk({e.tag, ".busy0"}, {31'd0, rs_busy[0]}, {31'd0, e.b0});
            chk({e.tag, ".val1"},  rs_val[63:32],      e.v1);
            chk({e.tag, ".busy1"}, {31'd0, rs_busy[1]}, {31'd0, e.b1});
        end
    endtask

    task automatic tick();
        edge_chk();
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        // Reads under reset stay cleared.
        set_rd("rst_rd", 2'b11, 5'd5, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("rst_busy_any", {31'd0, busy_any}, 32'd0);
        rst = 1'b0;

        // Load-source write, then read.
        set_wb(5'd3, 2'd1, 32'h1, 32'hDEADBEEF, 32'h0);
        tick();
        set_rd("rd_x3", 2'b11, 5'd3, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        tick();

        // Writes to x0 are dropped, even via bypass.
        set_wb(5'd0, 2'd0, 32'h1234, 32'h0, 32'h0);
        set_rd("x0_byp", 2'b11, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        set_rd("x0_rd", 2'b11, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();

        // Reserved select writes ALU data; CSR select.
        set_wb(5'd5, 2'd3, 32'hA5A50001, 32'h00000BAD, 32'h0000C0DE);
        tick();
        set_wb(5'd6, 2'd2, 32'h11111111, 32'h22222222, 32'h0000C5C5);
        tick();
        set_rd("sel_rd", 2'b11, 5'd6, 5'd5, 32'h0000C5C5, 1'b0, 32'hA5A50001, 1'b0);
        tick();

        // Same-cycle bypass.
        set_wb(5'd7, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0);
        set_rd("bypass", 2'b11, 5'd7, 5'd3, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF, 1'b0);
        tick();

        // Issue then read reports busy; write-back clears it.
        set_iss(5'd9);
        tick();
        chk("iss9_busy_any", {31'd0, busy_any}, 32'd1);
        set_rd("x9_busy", 2'b11, 5'd9, 5'd7, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
        tick();
        set_wb(5'd9, 2'd0, 32'h55, 32'h0, 32'h0);
        set_rd("x9_wb", 2'b11, 5'd9, 5'd9, 32'h55, 1'b0, 32'h55, 1'b0);
        tick();
        chk("wb9_busy_any", {31'd0, busy_any}, 32'd0);

        // Issue and write-back of the same rd: stays pending.
        set_iss(5'd4);
        set_wb(5'd4, 2'd0, 32'h44, 32'h0, 32'h0);
        tick();
        chk("coll_busy_any", {31'd0, busy_any}, 32'd1);
        set_rd("x4_coll", 2'b01, 5'd4, 5'd0, 32'h44, 1'b1, 32'h0, 1'b0);
        tick();
        set_wb(5'd4, 2'd1, 32'h0, 32'h45, 32'h0);
        set_rd("x4_clr", 2'b10, 5'd0, 5'd4, 32'h0, 1'b0, 32'h45, 1'b0);
        tick();
        chk("x4_busy_any", {31'd0, busy_any}, 32'd0);

        // Issue x0 never pends.
        set_iss(5'd0);
        tick();
        chk("iss0_busy_any", {31'd0, busy_any}, 32'd0);
        set_rd("x0_iss", 2'b11, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();

        // Flush while writing x2.
        set_iss(5'd1);
        tick();
        set_iss(5'd2);
        tick();
        set_iss(5'd3);
        set_rd("pre_flush", 2'b11, 5'd1, 5'd2, 32'h0, 1'b1, 32'h0, 1'b1);
        tick();
        chk("pre_flush_busy_any", {31'd0, busy_any}, 32'd1);
        flush = 1'b1;
        set_wb(5'd2, 2'd0, 32'h77, 32'h0, 32'h0);
        tick();
        chk("flush_busy_any", {31'd0, busy_any}, 32'd0);
        set_rd("flush_rd12", 2'b11, 5'd1, 5'd2, 32'h0, 1'b0, 32'h77, 1'b0);
        tick();
        set_rd("flush_rd3", 2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        tick();

        // Disabled port clears its outputs.
        set_iss(5'd8);
        set_rd("en_rd", 2'b11, 5'd3, 5'd6, 32'hDEADBEEF, 1'b0, 32'h0000C5C5, 1'b0);
        tick();
        set_rd("en_off", 2'b00, 5'd3, 5'd8, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();

        // Asynchronous reset between edges.
        set_rd("pre_rst", 2'b11, 5'd3, 5'd8, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
        edge_chk();
        chk("pre_rst_busy_any", {31'd0, busy_any}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_val0", rs_val[31:0], 32'h0);
        chk("arst_busy1", {31'd0, rs_busy[1]}, 32'd0);
        chk("arst_busy_any", {31'd0, busy_any}, 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        set_rd("post_rst", 2'b11, 5'd3, 5'd6, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
